alu_share_arbiter: RTL and testbench

Shares the single combinational 64-bit ALU between two requesters: requester 0 is the main execute path and requester 1 is the branch/address helper. Requests are accepted with valid/ready handshakes and arbitrated round-robin. The winner's operands are registered, driven to the ALU for one cycle, and the result and zero flag are captured. The captured response is returned on a per-requester valid/ready channel.

---
 rtl/alu_share_arbiter.sv | 146 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with registered operands and a per-requester response channel.
// Optional: define ALU_ARB_OPCHK_EN to reject unsupported ALU ops with rsp_err.
`timescale 1ns/1ps
module alu_share_arbiter #(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_zero,
`ifdef ALU_ARB_OPCHK_EN
  output logic              rsp_err,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  logic              ptr;
  logic              owner;
  logic              winner;
  logic              accept;
  logic              rsp_done;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [CTRL_W-1:0] sel_ctrl;

`ifdef ALU_ARB_OPCHK_EN
  function automatic logic op_legal(input logic [CTRL_W-1:0] c);
    return (c == CTRL_W'(4'b0010)) || (c == CTRL_W'(4'b0000)) ||
           (c == CTRL_W'(4'b0001)) || (c == CTRL_W'(4'b0110));
  endfunction
`endif

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) winner = ptr;
    else if (req1_valid)          winner = 1'b1;
  end

  // reset_n gates ready so no handshake can be offered while reset is held.
  assign req0_ready = reset_n && (state == IDLE) && req0_valid && !winner;
  assign req1_ready = reset_n && (state == IDLE) && req1_valid &&  winner;
  assign accept     = req0_ready || req1_ready;

  assign sel_a    = winner ? req1_a    : req0_a;
  assign sel_b    = winner ? req1_b    : req0_b;
  assign sel_ctrl = winner ? req1_ctrl : req0_ctrl;

  assign rsp_done = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  assign busy     = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= winner;
            ptr   <= ~winner;
`ifdef ALU_ARB_OPCHK_EN
            // Illegal ops never reach the ALU; answer with an error response directly.
            if (!op_legal(sel_ctrl)) begin
              rsp_data   <= '0;
              rsp_zero   <= 1'b0;
              rsp_err    <= 1'b1;
              rsp0_valid <= ~winner;
              rsp1_valid <=  winner;
              state      <= RESP;
            end else
`endif
            begin
              alu_a    <= sel_a;
              alu_b    <= sel_b;
              alu_ctrl <= sel_ctrl;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          rsp_data   <= alu_result;
          rsp_zero   <= alu_zero;
`ifdef ALU_ARB_OPCHK_EN
          rsp_err    <= 1'b0;
`endif
          rsp0_valid <= ~owner;
          rsp1_valid <=  owner;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
            rsp_err    <= 1'b0;
`endif
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table of single ops plus
// hand-written sequences for alternation, backpressure and mid-op reset.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  localparam int W  = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [CW-1:0] req0_ctrl = '0, req1_ctrl = '0;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [CW-1:0] alu_ctrl;
  logic          alu_zero;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [W-1:0]  rsp_data;
  logic          rsp_zero;
  logic          busy;
`ifdef ALU_ARB_OPCHK_EN
  logic          rsp_err;
`endif

  int passed = 0;
  int total  = 0;
  logic [W-1:0]  last_a = '0, last_b = '0;
  logic [CW-1:0] last_ctrl = '0;

  typedef struct {
    logic          sel;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [CW-1:0] ctrl;
    logic [W-1:0]  exp_data;
    logic          exp_zero;
  } vec_t;
  vec_t vecs [6];

  alu_share_arbiter #(.WIDTH(W), .CTRL_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
`ifdef ALU_ARB_OPCHK_EN
    .rsp_err(rsp_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU standing in for the shared execution unit.
  always_comb begin
    case (alu_ctrl)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic sel, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [CW-1:0] c);
    if (sel) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c;
    end
  endtask

  task automatic wait_grant(input logic sel);
    int n = 0;
    #1;
    while (!(sel ? req1_ready : req0_ready) && n < 20) begin
      tick();
      n++;
    end
    check1("grant_ready", sel ? req1_ready : req0_ready, 1'b1);
    check1("other_ready", sel ? req0_ready : req1_ready, 1'b0);
  endtask

  // Called one step after the handshake edge; walks ISSUE, RESP and the return to IDLE.
  task automatic complete(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [CW-1:0] c, input logic [W-1:0] exp_data, input logic exp_zero);
    check1("issue_busy", busy, 1'b1);
    check("issue_alu_a", alu_a, a);
    check("issue_alu_b", alu_b, b);
    check("issue_alu_ctrl", 64'(alu_ctrl), 64'(c));
    check1("issue_no_rsp", rsp0_valid | rsp1_valid, 1'b0);
    check1("issue_no_ready", req0_ready | req1_ready, 1'b0);
    last_a = a; last_b = b; last_ctrl = c;
    tick();
    check1("resp_valid", sel ? rsp1_valid : rsp0_valid, 1'b1);
    check1("resp_other_valid", sel ? rsp0_valid : rsp1_valid, 1'b0);
    check("resp_data", rsp_data, exp_data);
    check1("resp_zero", rsp_zero, exp_zero);
    check1("resp_no_ready", req0_ready | req1_ready, 1'b0);
`ifdef ALU_ARB_OPCHK_EN
    check1("resp_err", rsp_err, 1'b0);
`endif
    tick();
    check1("idle_rsp_cleared", rsp0_valid | rsp1_valid, 1'b0);
    check1("idle_busy", busy, 1'b0);
  endtask

  task automatic do_op(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [CW-1:0] c, input logic [W-1:0] exp_data, input logic exp_zero);
    set_req(sel, 1'b1, a, b, c);
    wait_grant(sel);
    tick();
    set_req(sel, 1'b0, a, b, c);
    complete(sel, a, b, c, exp_data, exp_zero);
  endtask

  initial begin
    vecs[0] = '{1'b1, 64'h0F, 64'hFF, 4'b0000, 64'h0F, 1'b0};
    vecs[1] = '{1'b0, 64'h7, 64'h7, 4'b0110, 64'h0, 1'b1};
    vecs[2] = '{1'b1, 64'hF0, 64'h0F, 4'b0001, 64'hFF, 1'b0};
    vecs[3] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'b0010, 64'h0, 1'b1};
    vecs[4] = '{1'b0, 64'hAA, 64'h55, 4'b0000, 64'h0, 1'b1};
    vecs[5] = '{1'b1, 64'h3, 64'h5, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};

    // Reset held with a pending request: nothing may be offered.
    set_req(1'b0, 1'b1, 64'd5, 64'd3, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      check1("rst_ready0", req0_ready, 1'b0);
      check1("rst_busy", busy, 1'b0);
    end
    check("rst_alu_a", alu_a, 64'h0);
    check("rst_alu_b", alu_b, 64'h0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'h0);
    check("rst_rsp_data", rsp_data, 64'h0);
    check1("rst_rsp_zero", rsp_zero, 1'b0);
    check1("rst_rsp_valid", rsp0_valid | rsp1_valid, 1'b0);
`ifdef ALU_ARB_OPCHK_EN
    check1("rst_rsp_err", rsp_err, 1'b0);
`endif
    reset_n = 1'b1;
    #1;
    check1("first_idle_ready0", req0_ready, 1'b1);

    // First op straight out of reset: 5 + 3.
    tick();
    set_req(1'b0, 1'b0, 64'd5, 64'd3, 4'b0010);
    complete(1'b0, 64'd5, 64'd3, 4'b0010, 64'd8, 1'b0);

    foreach (vecs[i])
      do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].exp_data, vecs[i].exp_zero);

    // Both requesters valid continuously: grants must alternate 0,1,0,1.
    set_req(1'b0, 1'b1, 64'h7, 64'h7, 4'b0110);
    set_req(1'b1, 1'b1, 64'hF0, 64'h0F, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      logic w;
      w = (k % 2) == 1;
      wait_grant(w);
      tick();
      if (w) complete(1'b1, 64'hF0, 64'h0F, 4'b0001, 64'hFF, 1'b0);
      else   complete(1'b0, 64'h7, 64'h7, 4'b0110, 64'h0, 1'b1);
    end
    set_req(1'b0, 1'b0, 64'h0, 64'h0, 4'b0000);
    set_req(1'b1, 1'b0, 64'h0, 64'h0, 4'b0000);

    // Backpressure on requester 1 while requester 0 waits.
    rsp1_ready = 1'b0;
    set_req(1'b1, 1'b1, 64'h0F, 64'hFF, 4'b0000);
    wait_grant(1'b1);
    tick();
    set_req(1'b1, 1'b0, 64'h0F, 64'hFF, 4'b0000);
    set_req(1'b0, 1'b1, 64'h1, 64'h1, 4'b0010);
    #1;
    check1("bp_issue_no_ready0", req0_ready, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check1("bp_rsp1_valid", rsp1_valid, 1'b1);
      check1("bp_rsp0_valid", rsp0_valid, 1'b0);
      check("bp_rsp_data", rsp_data, 64'h0F);
      check1("bp_rsp_zero", rsp_zero, 1'b0);
      check1("bp_busy", busy, 1'b1);
      check1("bp_no_ready0", req0_ready, 1'b0);
      tick();
    end
    rsp1_ready = 1'b1;
    #1;
    check1("bp_release_valid", rsp1_valid, 1'b1);
    check1("bp_release_no_ready0", req0_ready, 1'b0);
    tick();
    check1("bp_done_valid", rsp1_valid, 1'b0);
    check1("bp_done_busy", busy, 1'b0);
    check1("bp_ready0_back", req0_ready, 1'b1);
    tick();
    set_req(1'b0, 1'b0, 64'h1, 64'h1, 4'b0010);
    complete(1'b0, 64'h1, 64'h1, 4'b0010, 64'h2, 1'b0);

    // Reset pulsed during ISSUE aborts the op and returns the pointer to requester 0.
    set_req(1'b0, 1'b1, 64'h9, 64'h4, 4'b0110);
    wait_grant(1'b0);
    tick();
    set_req(1'b0, 1'b0, 64'h9, 64'h4, 4'b0110);
    check1("abort_in_issue", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check1("abort_busy", busy, 1'b0);
    check("abort_alu_a", alu_a, 64'h0);
    check("abort_rsp_data", rsp_data, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check1("abort_no_rsp", rsp0_valid | rsp1_valid, 1'b0);
    end
    set_req(1'b0, 1'b1, 64'h2, 64'h3, 4'b0010);
    set_req(1'b1, 1'b1, 64'h1, 64'h2, 4'b0001);
    wait_grant(1'b0);
    tick();
    set_req(1'b0, 1'b0, 64'h2, 64'h3, 4'b0010);
    set_req(1'b1, 1'b0, 64'h1, 64'h2, 4'b0001);
    complete(1'b0, 64'h2, 64'h3, 4'b0010, 64'h5, 1'b0);

`ifdef ALU_ARB_OPCHK_EN
    // Illegal op: error response one cycle after the handshake, ALU untouched.
    set_req(1'b0, 1'b1, 64'd11, 64'd22, 4'b0111);
    wait_grant(1'b0);
    tick();
    set_req(1'b0, 1'b0, 64'd11, 64'd22, 4'b0111);
    check1("ill_rsp0_valid", rsp0_valid, 1'b1);
    check1("ill_rsp1_valid", rsp1_valid, 1'b0);
    check1("ill_rsp_err", rsp_err, 1'b1);
    check("ill_rsp_data", rsp_data, 64'h0);
    check1("ill_rsp_zero", rsp_zero, 1'b0);
    check1("ill_busy", busy, 1'b1);
    check("ill_alu_a", alu_a, last_a);
    check("ill_alu_b", alu_b, last_b);
    check("ill_alu_ctrl", 64'(alu_ctrl), 64'(last_ctrl));
    tick();
    check1("ill_done_valid", rsp0_valid, 1'b0);
    check1("ill_done_busy", busy, 1'b0);
    do_op(1'b0, 64'd1, 64'd1, 4'b0010, 64'd2, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
